// File: rtl/dpr_arb_pkg.sv
// dpr_arb_pkg: shared types and defaults for the dual-port RAM arbiter.
//   NUM_REQ/DATA_W/ADDR_W : default configuration
//   MAX_REQ/IDX_W         : requester index space (up to 8 requesters)
//   port_tag_t            : per-RAM-port tag carried alongside an access
//   req_rec_t             : one requester's access fields {we, addr, wdata}
//   rr_wrap()             : (base + ofs) mod n for round-robin indexing
package dpr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 6;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic             vld;
    logic             rd;
    logic [IDX_W-1:0] idx;
  } port_tag_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_rec_t;

  // base < n and ofs < n always, so one subtraction is enough to wrap.
  function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base,
                                               input int unsigned ofs,
                                               input int unsigned n);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= n) s = s - n;
    return s[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/dpr_arbiter_if.sv
// dpr_arbiter_if: requester-side bus of the RAM arbiter.
//   req/req_we/req_addr/req_wdata : packed per-requester access requests
//   gnt                           : accept strobe, one bit per requester
//   rsp_valid/rsp_data            : read response pulse and packed data
// master = client side, slave = arbiter side.
interface dpr_arbiter_if #(
  parameter int NUM_REQ = dpr_arb_pkg::NUM_REQ,
  parameter int DATA_W  = dpr_arb_pkg::DATA_W,
  parameter int ADDR_W  = dpr_arb_pkg::ADDR_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_data;

  modport master (output req, req_we, req_addr, req_wdata,
                  input  gnt, rsp_valid, rsp_data);
  modport slave  (input  req, req_we, req_addr, req_wdata,
                  output gnt, rsp_valid, rsp_data);
endinterface

// File: rtl/dpr_rr_picker.sv
// dpr_rr_picker: combinational round-robin scan.
//   req        : request vector, zero-padded to MAX_REQ
//   rr_ptr     : index where the scan starts
//   first_*    : first requesting index at or after rr_ptr (wrapping)
//   second_*   : next requesting index after the first one
module dpr_rr_picker #(
  parameter int NUM_REQ = dpr_arb_pkg::NUM_REQ
) (
  input  logic [dpr_arb_pkg::MAX_REQ-1:0] req,
  input  logic [dpr_arb_pkg::IDX_W-1:0]   rr_ptr,
  output logic                            first_vld,
  output logic [dpr_arb_pkg::IDX_W-1:0]   first_idx,
  output logic                            second_vld,
  output logic [dpr_arb_pkg::IDX_W-1:0]   second_idx
);
  import dpr_arb_pkg::*;

  logic [IDX_W-1:0] cand;

  always_comb begin
    first_vld  = 1'b0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_idx = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_wrap(rr_ptr, k, NUM_REQ);
      if (req[cand]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = cand;
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = cand;
        end
      end
    end
  end

endmodule

// File: rtl/dpr_arbiter.sv
// dpr_arbiter: shares one registered-read dual-port RAM among NUM_REQ
// requesters. Up to two grants per cycle: first round-robin winner on
// port A, next requester on port B unless it conflicts with A.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cli (slave)       : requester bus (req/gnt/rsp)
//   ram_addr/data/we_x: registered RAM inputs, idle port drives 0
//   ram_q_a/b         : RAM read data, valid two cycles after accept
//   conflict_cnt      : only with DPR_ARB_CONFLICT_CNT_EN defined;
//                       saturating count of denied port-B candidates
module dpr_arbiter #(
  parameter int NUM_REQ = dpr_arb_pkg::NUM_REQ,
  parameter int DATA_W  = dpr_arb_pkg::DATA_W,
  parameter int ADDR_W  = dpr_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  dpr_arbiter_if.slave      cli,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_a,
  input  logic [DATA_W-1:0] ram_q_b
`ifdef DPR_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);
  import dpr_arb_pkg::*;

  // Requests fanned out to the full index space so the picker result
  // can index them directly; unused slots read as idle.
  logic [MAX_REQ-1:0] req_x;
  logic [MAX_REQ-1:0] we_x;
  logic [ADDR_W-1:0]  addr_x  [MAX_REQ];
  logic [DATA_W-1:0]  wdata_x [MAX_REQ];

  for (genvar g = 0; g < MAX_REQ; g++) begin : g_fan
    if (g < NUM_REQ) begin : g_on
      assign req_x[g]   = cli.req[g];
      assign we_x[g]    = cli.req_we[g];
      assign addr_x[g]  = cli.req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_x[g] = cli.req_wdata[g*DATA_W +: DATA_W];
    end else begin : g_off
      assign req_x[g]   = 1'b0;
      assign we_x[g]    = 1'b0;
      assign addr_x[g]  = '0;
      assign wdata_x[g] = '0;
    end
  end

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             a_vld, b_vld;
  logic [IDX_W-1:0] a_idx, b_idx;

  dpr_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_x),
    .rr_ptr     (rr_ptr_q),
    .first_vld  (a_vld),
    .first_idx  (a_idx),
    .second_vld (b_vld),
    .second_idx (b_idx)
  );

  // Same address with any write involved would make the A/B order
  // within the cycle observable, so B backs off and retries.
  logic conflict, gnt_a, gnt_b;
  assign conflict = a_vld & b_vld & (addr_x[b_idx] == addr_x[a_idx]) &
                    (we_x[a_idx] | we_x[b_idx]);
  assign gnt_a    = rst_n & a_vld;
  assign gnt_b    = rst_n & b_vld & ~conflict;

  // Stage 1: registered RAM inputs and port tags. Stage 2: tags aligned
  // with ram_q_x.
  logic [ADDR_W-1:0] ram_addr_a_q, ram_addr_a_d, ram_addr_b_q, ram_addr_b_d;
  logic [DATA_W-1:0] ram_data_a_q, ram_data_a_d, ram_data_b_q, ram_data_b_d;
  logic              ram_we_a_q, ram_we_a_d, ram_we_b_q, ram_we_b_d;
  port_tag_t         tag_a1_q, tag_a1_d, tag_b1_q, tag_b1_d;
  port_tag_t         tag_a2_q, tag_a2_d, tag_b2_q, tag_b2_d;

  always_comb begin
    ram_addr_a_d = '0;
    ram_data_a_d = '0;
    ram_we_a_d   = 1'b0;
    tag_a1_d     = '0;
    ram_addr_b_d = '0;
    ram_data_b_d = '0;
    ram_we_b_d   = 1'b0;
    tag_b1_d     = '0;
    if (gnt_a) begin
      ram_addr_a_d = addr_x[a_idx];
      ram_data_a_d = wdata_x[a_idx];
      ram_we_a_d   = we_x[a_idx];
      tag_a1_d     = '{vld: 1'b1, rd: ~we_x[a_idx], idx: a_idx};
    end
    if (gnt_b) begin
      ram_addr_b_d = addr_x[b_idx];
      ram_data_b_d = wdata_x[b_idx];
      ram_we_b_d   = we_x[b_idx];
      tag_b1_d     = '{vld: 1'b1, rd: ~we_x[b_idx], idx: b_idx};
    end
    tag_a2_d = tag_a1_q;
    tag_b2_d = tag_b1_q;
    // Restart just past the last granted requester.
    rr_ptr_d = rr_ptr_q;
    if (gnt_b)      rr_ptr_d = rr_wrap(b_idx, 1, NUM_REQ);
    else if (gnt_a) rr_ptr_d = rr_wrap(a_idx, 1, NUM_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      ram_addr_a_q <= '0;
      ram_data_a_q <= '0;
      ram_we_a_q   <= 1'b0;
      ram_addr_b_q <= '0;
      ram_data_b_q <= '0;
      ram_we_b_q   <= 1'b0;
      tag_a1_q     <= '0;
      tag_b1_q     <= '0;
      tag_a2_q     <= '0;
      tag_b2_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      ram_addr_a_q <= ram_addr_a_d;
      ram_data_a_q <= ram_data_a_d;
      ram_we_a_q   <= ram_we_a_d;
      ram_addr_b_q <= ram_addr_b_d;
      ram_data_b_q <= ram_data_b_d;
      ram_we_b_q   <= ram_we_b_d;
      tag_a1_q     <= tag_a1_d;
      tag_b1_q     <= tag_b1_d;
      tag_a2_q     <= tag_a2_d;
      tag_b2_q     <= tag_b2_d;
    end
  end

  assign ram_addr_a = ram_addr_a_q;
  assign ram_data_a = ram_data_a_q;
  assign ram_we_a   = ram_we_a_q;
  assign ram_addr_b = ram_addr_b_q;
  assign ram_data_b = ram_data_b_q;
  assign ram_we_b   = ram_we_b_q;

  // Grant decode and response routing. A requester never holds both
  // ports in one cycle, so at most one of hit_a/hit_b is set per lane.
  logic [NUM_REQ-1:0]        gnt_vec, rsp_vld_vec;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_vec;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic hit_a, hit_b;
    assign hit_a = tag_a2_q.vld & tag_a2_q.rd & (tag_a2_q.idx == IDX_W'(g));
    assign hit_b = tag_b2_q.vld & tag_b2_q.rd & (tag_b2_q.idx == IDX_W'(g));
    assign gnt_vec[g]     = (gnt_a & (a_idx == IDX_W'(g))) |
                            (gnt_b & (b_idx == IDX_W'(g)));
    assign rsp_vld_vec[g] = hit_a | hit_b;
    assign rsp_data_vec[g*DATA_W +: DATA_W] = hit_a ? ram_q_a :
                                              (hit_b ? ram_q_b : '0);
  end

  assign cli.gnt       = gnt_vec;
  assign cli.rsp_valid = rsp_vld_vec;
  assign cli.rsp_data  = rsp_data_vec;

`ifdef DPR_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_q <= '0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
